simple_cpu_core: RTL and testbench
==================================

SIMPLE_CPU_CORE -- requirements
Module: simple_cpu_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4: PC increment per executed instruction.
REQ-003 clock  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 imem_addr  output  32: instruction memory address, equal to the current PC.
REQ-006 imem_rdata  input  32: instruction word at imem_addr, combinational (same-cycle) from memory.
REQ-007 pc_value  output  32: current PC register.
REQ-008 instruction  output  32: current instruction register (IR) contents.
REQ-009 halted  output  1: high while IR holds the halt word.
REQ-010 dbg_sel  input  5: debug register index.
REQ-011 dbg_data  output  32: combinational read of register dbg_sel.

Function
REQ-012 Fetch: each rising edge, IR SHALL load imem_rdata and PC SHALL add PC_STEP (mod 2^32, wrap-around), unless halted or in reset.
REQ-013 Decode from IR: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25], imm={20 copies of [31], [31:20]}.
REQ-014 ADD: opcode 0110011, funct3 000, funct7 0000000 -> rd = rs1 + rs2.
REQ-015 SUB: opcode 0110011, funct3 000, funct7 0100000 -> rd = rs1 - rs2.
REQ-016 ADDI: opcode 0010011, funct3 000 -> rd = rs1 + imm.
REQ-017 Arithmetic SHALL be 32-bit two's complement, overflow discarded, no flags.
REQ-018 HALT: IR == 32'hFFFF_FFFF; asserts halted, suppresses register write, freezes PC and IR until reset.
REQ-019 Any other encoding SHALL be a no-op (no register write; PC and IR advance normally).
REQ-020 Writeback: result written to rd on the rising edge at which IR holds the instruction, i.e. one cycle after that instruction was fetched into IR.
REQ-021 Register file: 32 x 32-bit; three combinational read ports (rs1, rs2, dbg_sel); one synchronous write port.
REQ-022 x0 SHALL read as 0; writes to x0 SHALL be discarded.
REQ-023 Back-to-back dependent instructions SHALL need no stall; a written value SHALL be visible to the next instruction in IR.

Reset
REQ-024 On reset: PC=RESET_PC; IR=32'h0000_0000 (a no-op); x1..x31 = 0; halted=0.
REQ-025 Reset SHALL take priority over halt and over any register write on the same edge.
REQ-026 Reset asserted while halted SHALL restart fetch at RESET_PC.

Configuration
REQ-027 Macro SIMPLE_CPU_SUBI_EN defined: SUBI (opcode 0010011, funct3 001) SHALL write rd = rs1 - imm.
REQ-028 Macro SIMPLE_CPU_SUBI_EN undefined: that encoding SHALL be a no-op per REQ-019.

Structure
REQ-029 Package simple_cpu_pkg SHALL hold the opcode constants, the funct3 and funct7 constants, the HALT_INSN constant, and the decoded-operation enum typedef.
REQ-030 The register file SHALL be the one sub-module, register_file; PC, IR, decode and ALU SHALL be inline in simple_cpu_core.

Verification
REQ-031 Reset for 1 cycle, then release -> pc_value=0, instruction=0, halted=0; PC then advances 0, 4, 8, ....
REQ-032 Program at 0: 0x00500093 (addi x1,x0,5), 0x00108233 (add x4,x1,x1), 0x401202B3 (sub x5,x4,x1) -> x1=5, x4=10, x5=5, each written one cycle after its fetch.
REQ-033 Continue with 0x00229313 (subi x6,x5,2) -> x6=3 with SIMPLE_CPU_SUBI_EN defined; x6=0 without it.
REQ-034 Next word 0xFFFFFFFF -> halted=1; PC, IR and all registers stay unchanged for 10+ cycles.
REQ-035 Execute 0x00700013 (addi x0,x0,7) -> dbg_data for x0 stays 0. Execute 0xFFF00393 (addi x7,x0,-1) -> x7=32'hFFFF_FFFF.
REQ-036 Assert reset while halted -> next edge pc_value=0, halted=0, x1..x31 = 0.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: encodings, halt word and decoded-operation type for simple_cpu_core
package simple_cpu_pkg;
  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUBI = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_HALT} op_e;
endpackage

// File: rtl/simple_cpu_core_register_file.sv
// register_file: 32x32 registers, three combinational reads, one synchronous write; x0 reads zero
module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);
  logic [31:0] regs [32];
  always_ff @(posedge clock) begin
    if (reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
  assign rd3 = ra3 == 5'd0 ? '0 : regs[ra3];
endmodule

// File: rtl/simple_cpu_core.sv
// simple_cpu_core: single-cycle ADD/SUB/ADDI core with halt; SUBI enabled by macro SIMPLE_CPU_SUBI_EN
module simple_cpu_core
  import simple_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_value,
  output logic [31:0] instruction,
  output logic        halted,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);
  logic [31:0] pc, ir, a, b, imm, result;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic we;
  op_e op;
  assign {funct7, rs2, rs1, funct3, rd, opcode} = ir;
  assign imm = {{20{ir[31]}}, ir[31:20]};
  always_comb begin
    op = OP_NOP;
    if (ir == HALT_INSN) op = OP_HALT;
    else if (opcode == OPC_REG && funct3 == F3_ADD && funct7 == F7_ADD) op = OP_ADD;
    else if (opcode == OPC_REG && funct3 == F3_ADD && funct7 == F7_SUB) op = OP_SUB;
    else if (opcode == OPC_IMM && funct3 == F3_ADD) op = OP_ADDI;
`ifdef SIMPLE_CPU_SUBI_EN
    else if (opcode == OPC_IMM && funct3 == F3_SUBI) op = OP_SUBI;
`endif
  end
  assign result = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_ADDI ? a + imm : a - imm;
  assign we = !reset && (op == OP_ADD || op == OP_SUB || op == OP_ADDI || op == OP_SUBI);
  assign halted = op == OP_HALT;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (!halted) begin
      pc <= pc + 32'(PC_STEP);
      ir <= imem_rdata;
    end
  end
  register_file u_rf (
    .clock(clock), .reset(reset), .we(we), .wa(rd), .wd(result),
    .ra1(rs1), .ra2(rs2), .ra3(dbg_sel), .rd1(a), .rd2(b), .rd3(dbg_data)
  );
  assign imem_addr = pc;
  assign pc_value = pc;
  assign instruction = ir;
endmodule

// File: tb/tb_simple_cpu_core.sv
// tb_simple_cpu_core: directed program runs with hand-computed register/PC expectations
module tb_simple_cpu_core;
  logic clock = 0, reset = 1, halted;
  logic [31:0] imem_addr, imem_rdata, pc_value, instruction, dbg_data;
  logic [4:0] dbg_sel = 0;
  logic [31:0] mem [16];
  int n_cmp = 0, n_err = 0;
  always #5 clock = ~clock;
  assign imem_rdata = imem_addr < 32'd64 ? mem[imem_addr[5:2]] : 32'h0;
  simple_cpu_core dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_value(pc_value), .instruction(instruction), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk_reg(input int idx, input logic [31:0] exp);
    dbg_sel = 5'(idx);
    #1;
    check($sformatf("x%0d", idx), dbg_data, exp);
  endtask
  task automatic chk_core(input string tag, input logic [31:0] pc, input logic [31:0] ir, input logic h);
    check({tag, "_pc"}, pc_value, pc);
    check({tag, "_ir"}, instruction, ir);
    check({tag, "_halted"}, 32'(halted), 32'(h));
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00108233;
    mem[2] = 32'h401202B3;
    mem[3] = 32'h00229313;
    mem[4] = 32'hFFFFFFFF;
    step();
    reset = 0;
    chk_core("reset", 32'd0, 32'h0, 1'b0);
    step();
    chk_core("fetch1", 32'd4, 32'h00500093, 1'b0);
    chk_reg(1, 32'd0);
    step();
    chk_core("fetch2", 32'd8, 32'h00108233, 1'b0);
    chk_reg(1, 32'd5);
    chk_reg(4, 32'd0);
    step();
    chk_reg(4, 32'd10);
    step();
    chk_reg(5, 32'd5);
    step();
`ifdef SIMPLE_CPU_SUBI_EN
    chk_reg(6, 32'd3);
`else
    chk_reg(6, 32'd0);
`endif
    chk_core("halt", 32'd20, 32'hFFFFFFFF, 1'b1);
    repeat (12) step();
    chk_core("frozen", 32'd20, 32'hFFFFFFFF, 1'b1);
    chk_reg(1, 32'd5);
    chk_reg(4, 32'd10);
    chk_reg(5, 32'd5);
    reset = 1;
    step();
    chk_core("rst_halted", 32'd0, 32'h0, 1'b0);
    chk_reg(1, 32'd0);
    chk_reg(4, 32'd0);
    chk_reg(5, 32'd0);
    mem[0] = 32'h00700013;
    mem[1] = 32'hFFF00393;
    mem[2] = 32'hFFFFFFFF;
    reset = 0;
    step();
    chk_core("x0prog", 32'd4, 32'h00700013, 1'b0);
    step();
    chk_reg(0, 32'd0);
    step();
    chk_reg(7, 32'hFFFFFFFF);
    chk_core("halt2", 32'd12, 32'hFFFFFFFF, 1'b1);
    mem[0] = 32'h00500093;
    mem[1] = 32'h0010A0B3;
    reset = 1;
    step();
    reset = 0;
    step();
    reset = 1;
    step();
    chk_reg(1, 32'd0);
    chk_core("rst_prio", 32'd0, 32'h0, 1'b0);
    reset = 0;
    step();
    step();
    chk_reg(1, 32'd5);
    step();
    chk_reg(1, 32'd5);
    chk_core("nop", 32'd12, 32'hFFFFFFFF, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
